alu_issue_buf: RTL and testbench

ALU_ISSUE_BUF -- requirements
Module: alu_issue_buf

---
 rtl/alu_issue_buf_pkg.sv | 23 ++
 rtl/alu_funct_decode.sv | 23 ++
 rtl/alu_issue_buf.sv | 98 +++++++++
 tb/tb_alu_issue_buf.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_buf_pkg.sv
// rtl/alu_issue_buf_pkg.sv - shared funct codes and logic-unit select codes for the ALU issue buffer
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

package alu_issue_buf_pkg;

  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_AND     = 3'b000,
    ALU_OR      = 3'b001,
    ALU_NOR     = 3'b010,
    ALU_XOR     = 3'b011,
    ALU_SLT     = 3'b100,
    ALU_ILLEGAL = 3'b111
  } alu_opsel_e;

endpackage

// File: rtl/alu_funct_decode.sv
// rtl/alu_funct_decode.sv - R-type funct to logic-unit select decoder
module alu_funct_decode
  import alu_issue_buf_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] opsel,
  output logic       illegal
);

  always_comb begin
    opsel   = ALU_ILLEGAL;
    illegal = 1'b1;
    case (funct)
      FUNCT_AND: begin opsel = ALU_AND; illegal = 1'b0; end
      FUNCT_OR:  begin opsel = ALU_OR;  illegal = 1'b0; end
      FUNCT_NOR: begin opsel = ALU_NOR; illegal = 1'b0; end
      FUNCT_XOR: begin opsel = ALU_XOR; illegal = 1'b0; end
      FUNCT_SLT: begin opsel = ALU_SLT; illegal = 1'b0; end
      default:   begin opsel = ALU_ILLEGAL; illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/alu_issue_buf.sv
// rtl/alu_issue_buf.sv - two-entry decoded-op FIFO between issue and the logic unit
module alu_issue_buf
  import alu_issue_buf_pkg::*;
#(
  parameter int WIDTH = `REG_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_funct,
  input  logic [WIDTH-1:0] in_op_a,
  input  logic [WIDTH-1:0] in_op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_op_a,
  output logic [WIDTH-1:0] out_op_b,
  output logic [2:0]       out_log_opsel,
  output logic             out_illegal,
  output logic [7:0]       illegal_cnt
);

  localparam int DEPTH = 2;

  logic [WIDTH-1:0] mem_a     [DEPTH];
  logic [WIDTH-1:0] mem_b     [DEPTH];
  logic [2:0]       mem_opsel [DEPTH];
  logic             mem_ill   [DEPTH];

  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;

  logic [2:0] dec_opsel;
  logic       dec_illegal;
  logic       push;
  logic       pop;

  alu_funct_decode u_decode (
    .funct   (in_funct),
    .opsel   (dec_opsel),
    .illegal (dec_illegal)
  );

  // Ready depends only on registered occupancy so it never combinationally loops through out_ready.
  assign in_ready  = rst_n & ~flush & (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_op_a      = mem_a[rd_ptr];
  assign out_op_b      = mem_b[rd_ptr];
  assign out_log_opsel = mem_opsel[rd_ptr];
  assign out_illegal   = out_valid & mem_ill[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Flush leaves entry contents alone; only the pointers and count forget them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i]     <= '0;
        mem_b[i]     <= '0;
        mem_opsel[i] <= 3'b000;
        mem_ill[i]   <= 1'b0;
      end
    end else if (push) begin
      mem_a[wr_ptr]     <= in_op_a;
      mem_b[wr_ptr]     <= in_op_b;
      mem_opsel[wr_ptr] <= dec_opsel;
      mem_ill[wr_ptr]   <= dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_cnt <= 8'd0;
    end else if (push && dec_illegal && (illegal_cnt != 8'hFF)) begin
      illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue_buf.sv
// tb/tb_alu_issue_buf.sv - scoreboard bench for alu_issue_buf
module tb_alu_issue_buf;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  opsel;
    logic        ill;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_illegal;
  logic [5:0]  in_funct;
  logic [31:0] in_op_a, in_op_b, out_op_a, out_op_b;
  logic [2:0]  out_log_opsel;
  logic [7:0]  illegal_cnt;

  int     tests = 0;
  int     fails = 0;
  entry_t sb[$];
  int     exp_cnt = 0;

  always #5 clk = ~clk;

  alu_issue_buf #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_op_a(in_op_a), .in_op_b(in_op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b),
    .out_log_opsel(out_log_opsel), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  function automatic entry_t model(logic [5:0] f, logic [31:0] a, logic [31:0] b);
    entry_t e;
    e.a = a;
    e.b = b;
    e.ill = 1'b0;
    case (f)
      6'h24:   e.opsel = 3'b000;
      6'h25:   e.opsel = 3'b001;
      6'h27:   e.opsel = 3'b010;
      6'h26:   e.opsel = 3'b011;
      6'h2A:   e.opsel = 3'b100;
      default: begin e.opsel = 3'b111; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    in_funct = f;
    in_op_a  = a;
    in_op_b  = b;
  endtask

  // Decide fire conditions just before the edge, then advance to mid-low-phase.
  task automatic tick();
    logic   fin, fout;
    entry_t e;
    #1;
    fin  = in_valid && in_ready;
    fout = out_valid && out_ready;
    if (!rst_n) begin
      sb.delete();
      exp_cnt = 0;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (fout) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("pop_a", out_op_a, e.a);
          check("pop_b", out_op_b, e.b);
          check("pop_opsel", out_log_opsel, e.opsel);
          check("pop_illegal", out_illegal, e.ill);
        end
      end
      if (fin) begin
        e = model(in_funct, in_op_a, in_op_b);
        sb.push_back(e);
        if (e.ill && exp_cnt < 255) exp_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check("illegal_cnt_model", illegal_cnt, exp_cnt);
    check("out_valid_model", out_valid, sb.size() != 0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    @(negedge clk);
    tick();
    tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_op_a", out_op_a, 32'h0);
    check("rst_op_b", out_op_b, 32'h0);
    check("rst_opsel", out_log_opsel, 3'b000);
    check("rst_illegal", out_illegal, 1'b0);
    check("rst_illegal_cnt", illegal_cnt, 8'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // single AND op, one-cycle latency from empty
    drive(1'b1, 6'h24, 32'hF0F0F0F0, 32'hFF00FF00);
    tick();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    check("and_valid", out_valid, 1'b1);
    check("and_opsel", out_log_opsel, 3'b000);
    check("and_a", out_op_a, 32'hF0F0F0F0);
    check("and_b", out_op_b, 32'hFF00FF00);
    check("and_illegal", out_illegal, 1'b0);
    tick();
    check("and_stable_opsel", out_log_opsel, 3'b000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // backpressure: fill, refuse third, drain in order
    drive(1'b1, 6'h25, 32'h11111111, 32'h22222222);
    tick();
    drive(1'b1, 6'h27, 32'h33333333, 32'h44444444);
    tick();
    drive(1'b1, 6'h26, 32'h55555555, 32'h66666666);
    #1;
    check("full_in_ready", in_ready, 1'b0);
    check("full_head_opsel", out_log_opsel, 3'b001);
    tick();
    out_ready = 1'b1;
    check("full2_in_ready", in_ready, 1'b0);
    tick();
    check("freed_in_ready", in_ready, 1'b1);
    check("second_head_opsel", out_log_opsel, 3'b010);
    tick();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    check("xor_head_opsel", out_log_opsel, 3'b011);
    tick();
    out_ready = 1'b0;

    // simultaneous push/pop at count 1
    drive(1'b1, 6'h24, 32'hA5A5A5A5, 32'h5A5A5A5A);
    tick();
    drive(1'b1, 6'h2A, 32'h00000007, 32'h00000009);
    out_ready = 1'b1;
    tick();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    check("pp_valid", out_valid, 1'b1);
    check("pp_in_ready", in_ready, 1'b1);
    check("pp_opsel", out_log_opsel, 3'b100);
    check("pp_a", out_op_a, 32'h00000007);
    tick();
    check("pp_empty", out_valid, 1'b0);
    out_ready = 1'b0;

    // one illegal funct
    drive(1'b1, 6'h20, 32'hDEADBEEF, 32'h12345678);
    tick();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    check("ill_flag", out_illegal, 1'b1);
    check("ill_opsel", out_log_opsel, 3'b111);
    check("ill_cnt1", illegal_cnt, 8'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // flush with two held and a pending illegal offer
    drive(1'b1, 6'h25, 32'h0000AAAA, 32'h0000BBBB);
    tick();
    drive(1'b1, 6'h20, 32'h0000CCCC, 32'h0000DDDD);
    tick();
    check("pre_flush_cnt", illegal_cnt, 8'd2);
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 6'h20, 32'h1, 32'h2);
    #1;
    check("flush_in_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    #1;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready_after", in_ready, 1'b1);
    check("flush_cnt_kept", illegal_cnt, 8'd2);

    // saturate the illegal counter
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 6'h30 | 6'($urandom_range(0, 7)), $urandom, $urandom);
      tick();
    end
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    for (int i = 0; i < 8 && out_valid; i++) tick();
    check("drain_empty", out_valid, 1'b0);
    check("ill_cnt_sat", illegal_cnt, 8'd255);
    out_ready = 1'b0;

    // reset while full
    drive(1'b1, 6'h24, 32'h01010101, 32'h02020202);
    tick();
    drive(1'b1, 6'h26, 32'h03030303, 32'h04040404);
    tick();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_cnt", illegal_cnt, 8'd0);
    check("midrst_in_ready", in_ready, 1'b1);
    drive(1'b1, 6'h27, 32'hCAFEF00D, 32'h0BADC0DE);
    tick();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    check("midrst_push_valid", out_valid, 1'b1);
    check("midrst_push_opsel", out_log_opsel, 3'b010);
    check("midrst_push_a", out_op_a, 32'hCAFEF00D);
    out_ready = 1'b1;
    tick();
    check("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
